shift_op_sequencer: RTL
=======================

Name: shift_op_sequencer

Overview:
- Controller that sequences a 32-bit shift core to execute one ARM shifter-operand operation per request: LSL, LSR, ASR, ROR and RRX, including the register-specified amount rules (0, 32, >32) and the carry-out.
- Sits between decode/operand fetch and the ALU operand-2 input.
- Valid/ready handshake on both sides; one operation in flight.
- Two-pass FSM reuses a single 5-bit right/left shift core.

Parameters:
- DATA_W, 32, operand width; only 32 is supported.
- CNT_W, 16, width of the statistics counters (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  high only in IDLE
- req_type  in  3  0=LSL 1=LSR 2=ASR 3=ROR 4=RRX; 5-7 treated as LSL
- req_imm  in  1  1 = immediate form (5-bit amount), 0 = register form (8-bit amount)
- req_amount  in  8  shift amount; only [4:0] used when req_imm=1
- req_data  in  32  operand
- req_carry_in  in  1  current C flag
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts
- rsp_data  out  32  shifted result
- rsp_carry  out  1  shifter carry-out

Behaviour:
- Accept on req_valid && req_ready. Operands are latched, and the request fields are ignored afterwards.
- Immediate remap at accept:
  - LSR #0 becomes LSR 32.
  - ASR #0 becomes ASR 32.
  - ROR #0 becomes RRX.
  - LSL #0 stays 0.
- States: IDLE, PASS1, PASS2, RESP.
  - IDLE to PASS1 on accept when the op is two-pass.
  - IDLE to RESP on accept for single-cycle ops.
  - PASS1 to PASS2 to RESP, one cycle each.
  - RESP to IDLE when rsp_ready.
- Two-pass ops (n = amount, 1..31):
  - LSL: PASS1 gives data<<n; PASS2 gives data<<(n-1), and C is bit 31 of that.
  - LSR/ASR: PASS1 gives the shift by n; PASS2 gives the shift by n-1, and C is bit 0 of that.
  - ROR with amount[4:0]!=0: PASS1 gives data>>n; PASS2 gives data<<(32-n). The result is the OR of the two passes; C = result[31].
- Single-cycle ops (result registered directly):
  - amount 0 (LSL/LSR/ASR/ROR): data unchanged, C=carry_in.
  - LSL 32: 0, C=data[0]. LSL >32: 0, C=0.
  - LSR 32: 0, C=data[31]. LSR >32: 0, C=0.
  - ASR >=32: every bit = data[31], C=data[31].
  - ROR with amount[4:0]=0 and amount!=0: data unchanged, C=data[31].
  - RRX: {carry_in, data[31:1]}, C=data[0].
- Latency from accept to rsp_valid: two-pass ops 3 cycles; single-cycle ops 1 cycle.
- rsp_data/rsp_carry are stable while rsp_valid && !rsp_ready. There is no accept in the cycle rsp is consumed; req_ready rises the following cycle.
- Reset values:
  - state=IDLE, req_ready=0 during reset, then 1.
  - rsp_valid=0, rsp_data=0, rsp_carry=0.
  - Reset mid-operation aborts the op with no response.

Optional Feature:
- Macro SHIFT_OP_SEQUENCER_STATS_EN.
- When defined, two extra output ports exist:
  - stat_ops (CNT_W): increments on every rsp handshake.
  - stat_busy (CNT_W): increments every cycle state!=IDLE.
  - Both saturate at all-ones and clear on rst.
- When undefined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package shift_pkg holds:
  - shift-type encodings (SH_LSL..SH_RRX)
  - FSM state encoding
  - DATA_W constant
- One sub-module, shift_core: combinational 32-bit shift with inputs data, amt[4:0], dir (left/right) and arith, output result. It is instantiated once and muxed by the FSM.

Test Plan:
- LSR reg, amount 4, data 0x80000010 -> rsp 0x08000001, C=0, rsp_valid 3 cycles after accept.
- ASR reg 8, data 0x80000000 -> 0xFF800000, C=0. ASR reg 40, same data -> 0xFFFFFFFF, C=1, 1-cycle latency.
- ROR reg 8, data 0x12345678 -> 0x78123456, C=0. ROR reg 32, data 0x80000001 -> 0x80000001, C=1.
- Immediate encodings:
  - imm ROR #0 (RRX) with carry_in=1, data 0x00000003 -> 0x80000001, C=1.
  - imm LSR #0, data 0x80000000 -> 0, C=1.
- LSL reg 32, data 0xFFFFFFFF -> 0, C=1. LSL reg 33 -> 0, C=0. LSL reg 0 with carry_in=1 -> data, C=1.
- Backpressure:
  - Hold rsp_ready=0 for 5 cycles: rsp stable and req_ready=0 throughout.
  - Assert rst during PASS2: next cycle rsp_valid=0, state IDLE.
  - A new request after reset completes correctly.

Source files
------------

// File: rtl/shift_pkg.sv
// ============================================================================
// Module   : shift_pkg
// Brief    : Shared encodings for the ARM shifter-operand sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    localparam int SHIFT_DATA_W = 32;

    localparam logic [2:0] SH_LSL = 3'd0;
    localparam logic [2:0] SH_LSR = 3'd1;
    localparam logic [2:0] SH_ASR = 3'd2;
    localparam logic [2:0] SH_ROR = 3'd3;
    localparam logic [2:0] SH_RRX = 3'd4;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/shift_core.sv
// ============================================================================
// Module   : shift_core
// Brief    : Combinational 32-bit shifter, 5-bit amount, left/right, logical/arith.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_core
    import shift_pkg::*;
(
    input  logic [SHIFT_DATA_W-1:0] data,
    input  logic [4:0]              amt,
    input  logic                    dir,
    input  logic                    arith,
    output logic [SHIFT_DATA_W-1:0] result
);

    always_comb begin
        if (dir == DIR_LEFT) begin
            result = data << amt;
        end else if (arith) begin
            result = SHIFT_DATA_W'($signed(data) >>> amt);
        end else begin
            result = data >> amt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/shift_op_sequencer.sv
// ============================================================================
// Module   : shift_op_sequencer
// Brief    : Sequences one ARM shifter-operand op through a shared shift core.
//            Optional statistics counters: SHIFT_OP_SEQUENCER_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_op_sequencer
    import shift_pkg::*;
#(
    parameter int DATA_W = SHIFT_DATA_W
`ifdef SHIFT_OP_SEQUENCER_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_type,
    input  logic              req_imm,
    input  logic [7:0]        req_amount,
    input  logic [DATA_W-1:0] req_data,
    input  logic              req_carry_in,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_carry
`ifdef SHIFT_OP_SEQUENCER_STATS_EN
    ,
    output logic [CNT_W-1:0]  stat_ops,
    output logic [CNT_W-1:0]  stat_busy
`endif
);

    state_t            state;
    logic [2:0]        op_r;
    logic [4:0]        n_r;
    logic [DATA_W-1:0] data_r;
    logic [DATA_W-1:0] acc_r;

    logic [2:0]        eff_type;
    logic [7:0]        eff_amt;
    logic              two_pass;
    logic [DATA_W-1:0] single_data;
    logic              single_carry;

    logic [4:0]        core_amt;
    logic              core_dir;
    logic              core_arith;
    logic [DATA_W-1:0] core_out;
    logic [DATA_W-1:0] ror_or;

    assign req_ready = (state == ST_IDLE) && !rst;

    // Normalise the request: unknown types act as LSL, immediate #0 remaps.
    always_comb begin
        eff_type = (req_type > SH_RRX) ? SH_LSL : req_type;
        eff_amt  = req_imm ? {3'b000, req_amount[4:0]} : req_amount;
        if (req_imm && (eff_amt == 8'd0)) begin
            if ((eff_type == SH_LSR) || (eff_type == SH_ASR)) begin
                eff_amt = 8'd32;
            end else if (eff_type == SH_ROR) begin
                eff_type = SH_RRX;
            end
        end
    end

    always_comb begin
        two_pass = 1'b0;
        if (eff_type == SH_ROR) begin
            two_pass = (eff_amt[4:0] != 5'd0);
        end else if ((eff_type == SH_LSL) || (eff_type == SH_LSR) || (eff_type == SH_ASR)) begin
            two_pass = (eff_amt != 8'd0) && (eff_amt < 8'd32);
        end
    end

    always_comb begin
        single_data  = req_data;
        single_carry = req_carry_in;
        case (eff_type)
            SH_LSL: begin
                if (eff_amt >= 8'd32) begin
                    single_data  = '0;
                    single_carry = (eff_amt == 8'd32) ? req_data[0] : 1'b0;
                end
            end
            SH_LSR: begin
                if (eff_amt >= 8'd32) begin
                    single_data  = '0;
                    single_carry = (eff_amt == 8'd32) ? req_data[DATA_W-1] : 1'b0;
                end
            end
            SH_ASR: begin
                if (eff_amt >= 8'd32) begin
                    single_data  = {DATA_W{req_data[DATA_W-1]}};
                    single_carry = req_data[DATA_W-1];
                end
            end
            SH_ROR: begin
                if (eff_amt != 8'd0) begin
                    single_carry = req_data[DATA_W-1];
                end
            end
            SH_RRX: begin
                single_data  = {req_carry_in, req_data[DATA_W-1:1]};
                single_carry = req_data[0];
            end
            default: begin
                single_data  = req_data;
                single_carry = req_carry_in;
            end
        endcase
    end

    // Second pass shifts by n-1 to expose the carry bit; ROR instead builds
    // the wrapped-around half with a left shift by 32-n.
    always_comb begin
        core_arith = (op_r == SH_ASR);
        core_dir   = (op_r == SH_LSL) || ((op_r == SH_ROR) && (state == ST_PASS2));
        if (state == ST_PASS1) begin
            core_amt = n_r;
        end else if (op_r == SH_ROR) begin
            core_amt = 5'd0 - n_r;
        end else begin
            core_amt = n_r - 5'd1;
        end
    end

    shift_core u_shift_core (
        .data   (data_r),
        .amt    (core_amt),
        .dir    (core_dir),
        .arith  (core_arith),
        .result (core_out)
    );

    assign ror_or = acc_r | core_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            op_r      <= SH_LSL;
            n_r       <= 5'd0;
            data_r    <= '0;
            acc_r     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        data_r <= req_data;
                        op_r   <= eff_type;
                        n_r    <= eff_amt[4:0];
                        if (two_pass) begin
                            state <= ST_PASS1;
                        end else begin
                            rsp_data  <= single_data;
                            rsp_carry <= single_carry;
                            rsp_valid <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_PASS1: begin
                    acc_r <= core_out;
                    state <= ST_PASS2;
                end
                ST_PASS2: begin
                    case (op_r)
                        SH_LSL: begin
                            rsp_data  <= acc_r;
                            rsp_carry <= core_out[DATA_W-1];
                        end
                        SH_ROR: begin
                            rsp_data  <= ror_or;
                            rsp_carry <= ror_or[DATA_W-1];
                        end
                        default: begin
                            rsp_data  <= acc_r;
                            rsp_carry <= core_out[0];
                        end
                    endcase
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SHIFT_OP_SEQUENCER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops  <= '0;
            stat_busy <= '0;
        end else begin
            if (rsp_valid && rsp_ready && (stat_ops != '1)) begin
                stat_ops <= stat_ops + 1'b1;
            end
            if ((state != ST_IDLE) && (stat_busy != '1)) begin
                stat_busy <= stat_busy + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire
